// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet RX decapsulator.
//   fifo_word_t : 74-bit FIFO word {user, last, keep[7:0], data[63:0]}
//   state_t     : decapsulator FSM states
//   sel_t       : realigner output-word source select
//   wire_mac / wire_etype : reorder header octets so the first octet on the
//                           wire becomes the most significant byte.
package eth_pkg;

  // Byte index inside beat1 where the payload starts, and where the
  // EtherType sits.
  localparam int PAYLOAD_OFS = 6;
  localparam int ETYPE_OFS   = 4;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } fifo_word_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR1    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DROP    = 3'd4,
    ST_TERM    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEL_SHIFT = 2'd0,  // {beat bytes 0-5, holdover bytes}
    SEL_FLUSH = 2'd1,  // holdover bytes only, after the final beat
    SEL_TAIL  = 2'd2   // beat1 bytes 6-7 only, frame ended on beat1
  } sel_t;

  // Terminator written after an overflow: an empty, errored last word.
  localparam fifo_word_t TERM_WORD = '{user: 1'b1, last: 1'b1, keep: 8'h00, data: 64'h0};

  function automatic logic [47:0] wire_mac(input logic [63:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
  endfunction

  function automatic logic [15:0] wire_etype(input logic [63:0] d);
    return {d[ETYPE_OFS*8 +: 8], d[ETYPE_OFS*8+8 +: 8]};
  endfunction

endpackage

// File: rtl/eth_realign.sv
// Payload realigner: strips the 14-byte header by shifting each payload
// beat down by 6 bytes, carrying the top 2 bytes of the previous beat.
//   clk156, sys_rst_n : clock, async active-low reset
//   tdata/tkeep/tuser : current input beat
//   load              : capture beat bytes 6-7 (+keep, +error) into holdover
//   sel               : source of the output word (see sel_t)
//   last              : the word being built closes the frame
//   word              : combinational FIFO word, registered by the top
module eth_realign
  import eth_pkg::*;
(
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic [63:0] tdata,
  input  logic [7:0]  tkeep,
  input  logic        tuser,
  input  logic        load,
  input  sel_t        sel,
  input  logic        last,
  output fifo_word_t  word
);

  logic [15:0] hold_q, hold_d;
  logic [1:0]  hold_keep_q, hold_keep_d;
  logic        hold_user_q, hold_user_d;

  always_comb begin
    hold_d      = hold_q;
    hold_keep_d = hold_keep_q;
    hold_user_d = hold_user_q;
    if (load) begin
      hold_d      = tdata[PAYLOAD_OFS*8 +: 16];
      hold_keep_d = tkeep[PAYLOAD_OFS +: 2];
      // The error flag is only meaningful from a tlast beat, which is the
      // only load that is ever followed by a flush.
      hold_user_d = ~tuser;
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_q      <= '0;
      hold_keep_q <= '0;
      hold_user_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_keep_q <= hold_keep_d;
      hold_user_q <= hold_user_d;
    end
  end

  always_comb begin
    word      = '0;
    word.last = last;
    case (sel)
      SEL_SHIFT: begin
        word.data = {tdata[PAYLOAD_OFS*8-1:0], hold_q};
        // tkeep is contiguous, so a partial final beat keeps 2+c bytes.
        word.keep = last ? {tkeep[PAYLOAD_OFS-1:0], 2'b11} : 8'hFF;
        word.user = last & ~tuser;
      end
      SEL_FLUSH: begin
        word.data = {48'h0, hold_q};
        word.keep = {6'h0, hold_keep_q};
        word.user = last & hold_user_q;
      end
      SEL_TAIL: begin
        word.data = {48'h0, tdata[PAYLOAD_OFS*8 +: 16]};
        word.keep = {6'h0, tkeep[PAYLOAD_OFS +: 2]};
        word.user = last & ~tuser;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/eth_rxdecap.sv
// Ethernet RX decapsulator: filters frames on destination MAC / EtherType,
// strips the 14-byte header and writes realigned payload words to a FIFO.
//   clk156, sys_rst_n  : clock, async active-low reset
//   s_axis_rx_*        : MAC RX stream (no tready; every valid beat is taken)
//   wr_en, din, full   : FIFO write port
//   cnt_ok/filt/ovf    : forwarded / filtered-or-runt / overflow-dropped frames
//   dbg_state          : current FSM state
// Handshake: input beats are consumed whenever s_axis_rx_tvalid is high. On
// the FIFO side a word is written when wr_en is high at a clock edge;
// wr_en = registered valid AND !full. A data word met by full is lost and
// the frame is aborted; the terminator word instead waits for full to drop.
module eth_rxdecap
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [15:0] ETHTYPE = 16'h88B5
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic [63:0] s_axis_rx_tdata,
  input  logic [7:0]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tvalid,
  input  logic        s_axis_rx_tlast,
  input  logic        s_axis_rx_tuser,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  output logic [31:0] cnt_ok,
  output logic [31:0] cnt_filt,
  output logic [31:0] cnt_ovf,
  output logic [2:0]  dbg_state
);

  state_t     state_q, state_d, rest_st;
  logic       dst_ok_q, dst_ok_d;
  logic       valid_q, valid_d;
  fifo_word_t word_q, word_d, rl_word;
  logic       term_pend_q, term_pend_d;
  logic [31:0] cnt_ok_q, cnt_ok_d, cnt_filt_q, cnt_filt_d, cnt_ovf_q, cnt_ovf_d;

  logic beat, is_term, ovf, term_wr, pend, mac_hit, accept;
  logic emit, load, rl_last, inc_filt, drop_new;
  sel_t sel;

  eth_realign u_realign (
    .clk156   (clk156),
    .sys_rst_n(sys_rst_n),
    .tdata    (s_axis_rx_tdata),
    .tkeep    (s_axis_rx_tkeep),
    .tuser    (s_axis_rx_tuser),
    .load     (load),
    .sel      (sel),
    .last     (rl_last),
    .word     (rl_word)
  );

  always_comb begin
    beat    = s_axis_rx_tvalid;
    // A real last word always carries at least one byte, so keep=0 marks
    // the terminator unambiguously.
    is_term = word_q.last && (word_q.keep == 8'h00);
    ovf     = valid_q && full && !is_term;
    term_wr = valid_q && !full && is_term;
    pend        = term_pend_q || ovf;
    term_pend_d = pend && !term_wr;
    rest_st     = term_pend_d ? ST_TERM : ST_IDLE;
    mac_hit = (wire_mac(s_axis_rx_tdata) == MY_MAC) ||
              (wire_mac(s_axis_rx_tdata) == 48'hFFFF_FFFF_FFFF);
    accept  = dst_ok_q && (wire_etype(s_axis_rx_tdata) == ETHTYPE);

    state_d  = state_q;
    dst_ok_d = dst_ok_q;
    emit     = 1'b0;
    load     = 1'b0;
    sel      = SEL_SHIFT;
    rl_last  = 1'b0;
    inc_filt = 1'b0;
    drop_new = 1'b0;

    case (state_q)
      // States that can see a beat0; FLUSH also closes the previous frame.
      ST_IDLE, ST_TERM, ST_FLUSH: begin
        if (state_q == ST_FLUSH && !ovf) begin
          emit    = 1'b1;
          sel     = SEL_FLUSH;
          rl_last = 1'b1;
        end
        state_d = rest_st;
        if (beat) begin
          if (pend) begin
            drop_new = 1'b1;
            if (!s_axis_rx_tlast) state_d = ST_DROP;
          end else if (s_axis_rx_tlast) begin
            inc_filt = 1'b1;
          end else begin
            state_d  = ST_HDR1;
            dst_ok_d = mac_hit;
          end
        end
      end
      ST_HDR1: begin
        if (ovf) begin
          state_d = (beat && s_axis_rx_tlast) ? rest_st : ST_DROP;
        end else if (beat) begin
          if (s_axis_rx_tlast) begin
            state_d = rest_st;
            // Only 7 or 8 valid bytes leave any payload behind the header.
            if (accept && s_axis_rx_tkeep[PAYLOAD_OFS]) begin
              emit    = 1'b1;
              sel     = SEL_TAIL;
              rl_last = 1'b1;
            end else begin
              inc_filt = 1'b1;
            end
          end else if (accept) begin
            load    = 1'b1;
            state_d = ST_PAYLOAD;
          end else begin
            inc_filt = 1'b1;
            state_d  = ST_DROP;
          end
        end
      end
      ST_PAYLOAD: begin
        if (ovf) begin
          state_d = (beat && s_axis_rx_tlast) ? rest_st : ST_DROP;
        end else if (beat) begin
          emit = 1'b1;
          load = 1'b1;
          if (s_axis_rx_tlast) begin
            // Bytes 6-7 of a long final beat spill into one more word.
            if (s_axis_rx_tkeep[PAYLOAD_OFS]) begin
              state_d = ST_FLUSH;
            end else begin
              rl_last = 1'b1;
              state_d = rest_st;
            end
          end
        end
      end
      ST_DROP: begin
        if (beat && s_axis_rx_tlast) state_d = rest_st;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    word_d  = word_q;
    if (ovf) begin
      valid_d = 1'b1;
      word_d  = TERM_WORD;
    end else if (valid_q && is_term && full) begin
      valid_d = 1'b1;
    end else if (emit) begin
      valid_d = 1'b1;
      word_d  = rl_word;
    end
  end

  always_comb begin
    wr_en      = valid_q && !full;
    cnt_ok_d   = cnt_ok_q + 32'(wr_en && word_q.last && !word_q.user);
    cnt_filt_d = cnt_filt_q + 32'(inc_filt);
    cnt_ovf_d  = cnt_ovf_q + 32'(ovf) + 32'(drop_new);
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      dst_ok_q    <= 1'b0;
      valid_q     <= 1'b0;
      word_q      <= '0;
      term_pend_q <= 1'b0;
      cnt_ok_q    <= '0;
      cnt_filt_q  <= '0;
      cnt_ovf_q   <= '0;
    end else begin
      state_q     <= state_d;
      dst_ok_q    <= dst_ok_d;
      valid_q     <= valid_d;
      word_q      <= word_d;
      term_pend_q <= term_pend_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_filt_q  <= cnt_filt_d;
      cnt_ovf_q   <= cnt_ovf_d;
    end
  end

  assign din       = word_q;
  assign cnt_ok    = cnt_ok_q;
  assign cnt_filt  = cnt_filt_q;
  assign cnt_ovf   = cnt_ovf_q;
  assign dbg_state = state_q;

endmodule
